// File: rtl/para_reg_topmodule.sv
// Registered W-bit adder: input register, Kogge-Stone carry network, output register.
// {c_out, sum} = a + b + c_in, two clock edges after the operands are sampled.
module para_reg_topmodule #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);

  localparam int unsigned Lvls = $clog2(W);

  logic [W-1:0] a_q, b_q;
  logic         cin_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      cin_q <= c_in;
    end
  end

  logic [W-1:0] g_bit, p_bit, g_base;

  assign g_bit  = a_q & b_q;
  assign p_bit  = a_q ^ b_q;
  // Carry-in folded into bit 0 so the prefix tree yields c_{i+1} directly.
  assign g_base = {g_bit[W-1:1], g_bit[0] | (p_bit[0] & cin_q)};

  for (genvar l = 0; l < int'(Lvls); l++) begin : g_lvl
    localparam int Dist = 2 ** l;
    logic [W-1:0] g_in, p_in, g_out, p_out;

    if (l == 0) begin : g_first
      assign g_in = g_base;
      assign p_in = p_bit;
    end else begin : g_next
      assign g_in = g_lvl[l-1].g_out;
      assign p_in = g_lvl[l-1].p_out;
    end

    for (genvar i = 0; i < int'(W); i++) begin : g_node
      if (i >= Dist) begin : g_op
        assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-Dist]);
        assign p_out[i] = p_in[i] & p_in[i-Dist];
      end else begin : g_pass
        assign g_out[i] = g_in[i];
        assign p_out[i] = p_in[i];
      end
    end
  end

  logic [W:0]   carry;
  logic [W-1:0] sum_d;
  logic         cout_d;

  assign carry  = {g_lvl[Lvls-1].g_out, cin_q};
  assign sum_d  = p_bit ^ carry[W-1:0];
  assign cout_d = carry[W];

  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      sum   <= sum_d;
      c_out <= cout_d;
    end
  end

endmodule

// File: tb/tb_para_reg_topmodule.sv
// Bench for para_reg_topmodule at W=16 and W=13; expected {c_out,sum} values queue up
// as operands are driven and are popped two edges later when the result is due.
module tb_para_reg_topmodule;

  logic        clk;
  logic        rst;
  logic        c_in;
  logic [15:0] a16, b16, sum16;
  logic        c_out16;
  logic [12:0] a13, b13, sum13;
  logic        c_out13;

  int unsigned n_vec;
  int unsigned n_bad;

  logic [16:0] q16[$];
  logic [13:0] q13[$];
  logic [16:0] e16;
  logic [13:0] e13;

  para_reg_topmodule #(.W(16)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .a    (a16),
    .b    (b16),
    .c_in (c_in),
    .sum  (sum16),
    .c_out(c_out16)
  );

  para_reg_topmodule #(.W(13)) dut13 (
    .clk  (clk),
    .rst  (rst),
    .a    (a13),
    .b    (b13),
    .c_in (c_in),
    .sum  (sum13),
    .c_out(c_out13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Applies one operation and queues its expected results. A reset also kills the
  // operation still sitting in the input register, so its queued entry becomes 0.
  task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic [12:0] wa,
                       input logic [12:0] wb, input logic ci, input logic r,
                       input logic [16:0] exp16);
    a16  = va;
    b16  = vb;
    a13  = wa;
    b13  = wb;
    c_in = ci;
    rst  = r;
    if (r) begin
      if (q16.size() > 0) q16[q16.size()-1] = '0;
      if (q13.size() > 0) q13[q13.size()-1] = '0;
      q16.push_back('0);
      q13.push_back('0);
    end else begin
      q16.push_back(exp16);
      q13.push_back({1'b0, wa} + {1'b0, wb} + {13'd0, ci});
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e16 = q16.pop_front();
      e13 = q13.pop_front();
      n_vec += 2;
      if ({c_out16, sum16} !== e16) begin
        n_bad++;
        $display("FAIL reset[%0d] w16: got %h, want %h", i, {c_out16, sum16}, e16);
      end
      if ({c_out13, sum13} !== e13) begin
        n_bad++;
        $display("FAIL reset[%0d] w13: got %h, want %h", i, {c_out13, sum13}, e13);
      end
      drive(16'hFFFF, 16'h0001, 13'h1FFF, 13'h0001, 1'b1, i < 2, 17'h10001);
    end
  endtask

  task automatic test_basic();
    logic [15:0] ta[3] = '{16'd100, 16'hFFFF, 16'hFFFF};
    logic [15:0] tb[3] = '{16'd23, 16'h0000, 16'hFFFF};
    logic        tc[3] = '{1'b0, 1'b1, 1'b1};
    logic [16:0] te[3] = '{17'h0007B, 17'h10000, 17'h1FFFF};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e16 = q16.pop_front();
      e13 = q13.pop_front();
      n_vec += 2;
      if ({c_out16, sum16} !== e16) begin
        n_bad++;
        $display("FAIL basic[%0d] w16: got %h, want %h", i, {c_out16, sum16}, e16);
      end
      if ({c_out13, sum13} !== e13) begin
        n_bad++;
        $display("FAIL basic[%0d] w13: got %h, want %h", i, {c_out13, sum13}, e13);
      end
      drive(ta[i], tb[i], ta[i][12:0], tb[i][12:0], tc[i], 1'b0, te[i]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta[3] = '{16'd1, 16'h8000, 16'h7FFF};
    logic [15:0] tb[3] = '{16'd2, 16'h8000, 16'h0000};
    logic        tc[3] = '{1'b0, 1'b0, 1'b1};
    logic [16:0] te[3] = '{17'h00003, 17'h10000, 17'h08000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e16 = q16.pop_front();
      e13 = q13.pop_front();
      n_vec += 2;
      if ({c_out16, sum16} !== e16) begin
        n_bad++;
        $display("FAIL b2b[%0d] w16: got %h, want %h", i, {c_out16, sum16}, e16);
      end
      if ({c_out13, sum13} !== e13) begin
        n_bad++;
        $display("FAIL b2b[%0d] w13: got %h, want %h", i, {c_out13, sum13}, e13);
      end
      drive(ta[i], tb[i], ta[i][12:0], tb[i][12:0], tc[i], 1'b0, te[i]);
    end
  endtask

  task automatic test_reset_mid();
    // 5+6 captured, then reset on the next edge: the 11 must never surface.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e16 = q16.pop_front();
      e13 = q13.pop_front();
      n_vec += 2;
      if ({c_out16, sum16} !== e16) begin
        n_bad++;
        $display("FAIL rst_mid[%0d] w16: got %h, want %h", i, {c_out16, sum16}, e16);
      end
      if ({c_out13, sum13} !== e13) begin
        n_bad++;
        $display("FAIL rst_mid[%0d] w13: got %h, want %h", i, {c_out13, sum13}, e13);
      end
      if (i == 0) drive(16'd5, 16'd6, 13'd5, 13'd6, 1'b0, 1'b0, 17'd11);
      else if (i == 1) drive(16'd7, 16'd8, 13'd7, 13'd8, 1'b0, 1'b1, 17'd15);
      else drive(16'd9, 16'd1, 13'd9, 13'd1, 1'b0, 1'b0, 17'd10);
    end
  endtask

  task automatic test_random(input int n);
    logic [15:0] ra, rb;
    logic [12:0] wa, wb;
    logic        rc;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e16 = q16.pop_front();
      e13 = q13.pop_front();
      n_vec += 2;
      if ({c_out16, sum16} !== e16) begin
        n_bad++;
        $display("FAIL random[%0d] w16: got %h, want %h", i, {c_out16, sum16}, e16);
      end
      if ({c_out13, sum13} !== e13) begin
        n_bad++;
        $display("FAIL random[%0d] w13: got %h, want %h", i, {c_out13, sum13}, e13);
      end
      ra = 16'($urandom);
      rb = 16'($urandom);
      wa = 13'($urandom);
      wb = 13'($urandom);
      rc = 1'($urandom);
      if (i % 4 == 1) ra = 16'hFFFF ^ rb;
      drive(ra, rb, wa, wb, rc, 1'b0, {1'b0, ra} + {1'b0, rb} + {16'd0, rc});
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      e16 = q16.pop_front();
      e13 = q13.pop_front();
      n_vec += 2;
      if ({c_out16, sum16} !== e16) begin
        n_bad++;
        $display("FAIL drain[%0d] w16: got %h, want %h", i, {c_out16, sum16}, e16);
      end
      if ({c_out13, sum13} !== e13) begin
        n_bad++;
        $display("FAIL drain[%0d] w13: got %h, want %h", i, {c_out13, sum13}, e13);
      end
      drive(16'd0, 16'd0, 13'd0, 13'd0, 1'b0, 1'b0, 17'd0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    // Result due at the first edge: reset is held there, so it is 0.
    q16.push_back('0);
    q13.push_back('0);
    drive(16'hFFFF, 16'h0001, 13'h1FFF, 13'h0001, 1'b1, 1'b1, 17'h10001);
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_random(10000);
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
